// File: rtl/card_reader_if.sv
// card_reader_if: deserialises the card's serial PIN frame, checks even parity and drives the eject motor.
// Define CARD_READER_SYNC_EN to synchronise the reader inputs and edge-detect card_strobe.
module card_reader_if #(
  parameter int PIN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int EJECT_CYCLES   = 50
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 card_present,
  input  logic                 card_strobe,
  input  logic                 card_data,
  input  logic                 card_spell_out,
  output logic                 insert,
  output logic [PIN_WIDTH-1:0] input_card_pin,
  output logic                 eject_motor,
  output logic                 read_error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int EW = $clog2(EJECT_CYCLES) + 1;
  localparam int BW = $clog2(PIN_WIDTH) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [EW-1:0] EJECT_LAST = EW'(EJECT_CYCLES - 1);
  localparam logic [EW-1:0] EJECT_MAX  = EW'(EJECT_CYCLES);
  localparam logic [BW-1:0] BIT_LAST   = BW'(PIN_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_SHIFT      = 3'd2,
    ST_PARITY     = 3'd3,
    ST_LOADED     = 3'd4,
    ST_EJECT      = 3'd5,
    ST_ERROR      = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [PIN_WIDTH-1:0] shift_q, shift_d;
  logic [PIN_WIDTH-1:0] pin_q, pin_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [EW-1:0]        eject_cnt_q, eject_cnt_d;
  logic                 insert_q, insert_d;
  logic                 eject_q, eject_d;
  logic                 error_q, error_d;
  logic                 present_s, strobe_s, data_s;
  logic                 timed_s, timeout_s;

  function automatic logic parity_ok(input logic [PIN_WIDTH-1:0] data, input logic par);
    return ~((^data) ^ par);
  endfunction

`ifdef CARD_READER_SYNC_EN
  logic [1:0] present_sync_q, strobe_sync_q, data_sync_q;
  logic       strobe_prev_q;

  // Two-flop synchronisers plus strobe rising-edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      present_sync_q <= 2'b00;
      strobe_sync_q  <= 2'b00;
      data_sync_q    <= 2'b00;
      strobe_prev_q  <= 1'b0;
    end else begin
      present_sync_q <= {present_sync_q[0], card_present};
      strobe_sync_q  <= {strobe_sync_q[0], card_strobe};
      data_sync_q    <= {data_sync_q[0], card_data};
      strobe_prev_q  <= strobe_sync_q[1];
    end
  end

  assign present_s = present_sync_q[1];
  assign strobe_s  = strobe_sync_q[1] & ~strobe_prev_q;
  assign data_s    = data_sync_q[1];
`else
  assign present_s = card_present;
  assign strobe_s  = card_strobe;
  assign data_s    = card_data;
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    pin_d       = pin_q;
    timer_d     = '0;
    eject_cnt_d = '0;
    timed_s     = (state_q == ST_WAIT_START) || (state_q == ST_SHIFT) || (state_q == ST_PARITY);
    timeout_s   = timed_s && !strobe_s && (timer_q == TIMER_LAST);

    // A strobe restarts the inter-bit timer even when its data is ignored
    if (!timed_s || strobe_s) begin
      timer_d = '0;
    end else if (timer_q == TIMER_MAX) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        shift_d   = '0;
        bit_cnt_d = '0;
        if (present_s) state_d = ST_WAIT_START;
        else           state_d = ST_IDLE;
      end
      ST_WAIT_START: begin
        if (strobe_s && data_s) begin
          state_d   = ST_SHIFT;
          shift_d   = '0;
          bit_cnt_d = '0;
        end else if (timeout_s) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_WAIT_START;
        end
      end
      ST_SHIFT: begin
        if (strobe_s) begin
          shift_d   = {shift_q[PIN_WIDTH-2:0], data_s};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BIT_LAST) state_d = ST_PARITY;
          else                       state_d = ST_SHIFT;
        end else if (timeout_s) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_PARITY: begin
        if (strobe_s) begin
          if (parity_ok(shift_q, data_s)) begin
            state_d = ST_LOADED;
            pin_d   = shift_q;
          end else begin
            state_d = ST_ERROR;
          end
        end else if (timeout_s) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_LOADED: begin
        if (card_spell_out) state_d = ST_EJECT;
        else                state_d = ST_LOADED;
      end
      ST_EJECT: begin
        if (eject_cnt_q == EJECT_LAST) state_d = ST_IDLE;
        else                           state_d = ST_EJECT;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Card removal outranks strobe, timeout and eject request
    if ((state_q != ST_IDLE) && !present_s) begin
      state_d   = ST_IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      timer_d   = '0;
    end else begin
      state_d = state_d;
    end

    if (state_d == ST_IDLE) pin_d = '0;
    else                    pin_d = pin_d;

    if (state_d != state_q) begin
      eject_cnt_d = '0;
    end else if ((state_q == ST_EJECT) || (state_q == ST_ERROR)) begin
      if (eject_cnt_q == EJECT_MAX) eject_cnt_d = eject_cnt_q;
      else                          eject_cnt_d = eject_cnt_q + EW'(1);
    end else begin
      eject_cnt_d = '0;
    end

    insert_d = (state_d == ST_LOADED);
    error_d  = (state_d == ST_ERROR);
    eject_d  = (state_d == ST_EJECT) || ((state_d == ST_ERROR) && (eject_cnt_d != EJECT_MAX));
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      pin_q       <= '0;
      bit_cnt_q   <= '0;
      timer_q     <= '0;
      eject_cnt_q <= '0;
      insert_q    <= 1'b0;
      eject_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      pin_q       <= pin_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      eject_cnt_q <= eject_cnt_d;
      insert_q    <= insert_d;
      eject_q     <= eject_d;
      error_q     <= error_d;
    end
  end

  assign insert         = insert_q;
  assign input_card_pin = pin_q;
  assign eject_motor    = eject_q;
  assign read_error     = error_q;

endmodule
